// File: rtl/sine_rom_sequencer.sv
// sine_rom_sequencer: shares one 1-cycle-latency sine ROM between channels A and B, one frame per tick.
// Define SINE_ROM_SEQ_OFFSET_EN to make channel B a phase-offset copy of A (adds port offset).
module sine_rom_sequencer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [ADDRESS_WIDTH-1:0] incr_a,
  input  logic [ADDRESS_WIDTH-1:0] incr_b,
`ifdef SINE_ROM_SEQ_OFFSET_EN
  input  logic [ADDRESS_WIDTH-1:0] offset,
`endif
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [DATA_WIDTH-1:0]    dout_a,
  output logic [DATA_WIDTH-1:0]    dout_b,
  output logic                     valid_a,
  output logic                     valid_b,
  output logic                     busy,
  output logic                     overrun
);
  localparam logic [1:0] IDLE = 2'd0, RD_A = 2'd1, RD_B = 2'd2, CAP_B = 2'd3;
  logic [1:0] state;
  logic [ADDRESS_WIDTH-1:0] phase_a, inc_a_q, b_q, addr_b;
`ifdef SINE_ROM_SEQ_OFFSET_EN
  // b_q holds the frame's offset; B tracks A's phase
  assign addr_b = phase_a + b_q;
`else
  logic [ADDRESS_WIDTH-1:0] phase_b;
  assign addr_b = phase_b;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase_a <= '0;
`ifndef SINE_ROM_SEQ_OFFSET_EN
      phase_b <= '0;
`endif
      inc_a_q <= '0;
      b_q <= '0;
      rom_addr <= '0;
      dout_a <= '0;
      dout_b <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          rom_addr <= phase_a;
          inc_a_q <= incr_a;
`ifdef SINE_ROM_SEQ_OFFSET_EN
          b_q <= offset;
`else
          b_q <= incr_b;
`endif
          busy <= 1'b1;
          state <= RD_A;
        end
        RD_A: begin
          rom_addr <= addr_b;
          state <= RD_B;
        end
        RD_B: begin
          dout_a <= rom_dout;
          valid_a <= 1'b1;
          state <= CAP_B;
        end
        default: begin
          dout_b <= rom_dout;
          valid_b <= 1'b1;
          phase_a <= phase_a + inc_a_q;
`ifndef SINE_ROM_SEQ_OFFSET_EN
          phase_b <= phase_b + b_q;
`endif
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sine_rom_sequencer.sv
// tb_sine_rom_sequencer: identity ROM (rom[i]=i) plus a per-frame phase model of both channels.
module tb_sine_rom_sequencer;
  logic clk = 0, rst = 1, tick = 0;
  logic [7:0] incr_a = 0, incr_b = 0, rom_addr, rom_dout, dout_a, dout_b;
`ifdef SINE_ROM_SEQ_OFFSET_EN
  logic [7:0] offset = 0;
`endif
  logic valid_a, valid_b, busy, overrun;
  logic [7:0] rom [256];
  logic [7:0] pa, pb;
  int checks = 0, errors = 0;

  sine_rom_sequencer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .incr_a(incr_a), .incr_b(incr_b),
`ifdef SINE_ROM_SEQ_OFFSET_EN
    .offset(offset),
`endif
    .rom_addr(rom_addr), .rom_dout(rom_dout), .dout_a(dout_a), .dout_b(dout_b),
    .valid_a(valid_a), .valid_b(valid_b), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  initial for (int i = 0; i < 256; i++) rom[i] = 8'(i);
  always_ff @(posedge clk) rom_dout <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick = 0;
    step(); step();
    rst = 0;
    pa = 0; pb = 0;
    checks++;
    if ({rom_addr, dout_a, dout_b, valid_a, valid_b, busy, overrun} !== 28'h0) begin
      errors++;
      $display("FAIL reset: addr=%02h a=%02h b=%02h va=%b vb=%b busy=%b ovr=%b, expected all 0",
               rom_addr, dout_a, dout_b, valid_a, valid_b, busy, overrun);
    end
  endtask

  // One full frame; inputs are scrambled after the tick to prove they were latched.
  task automatic do_frame(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] of);
    logic [7:0] ea, eb;
    ea = pa;
`ifdef SINE_ROM_SEQ_OFFSET_EN
    eb = pa + of;
    offset = of;
`else
    eb = pb;
`endif
    incr_a = ia; incr_b = ib; tick = 1;
    step();
    tick = 0; incr_a = 8'($urandom); incr_b = 8'($urandom);
`ifdef SINE_ROM_SEQ_OFFSET_EN
    offset = 8'($urandom);
`endif
    checks++;
    if (busy !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL frame_start: busy=%b valid_a=%b, expected busy=1 valid_a=0", busy, valid_a);
    end
    step(); step();
    checks++;
    if (valid_a !== 1'b1 || valid_b !== 1'b0 || dout_a !== ea || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_a: va=%b vb=%b a=%02h busy=%b, expected va=1 vb=0 a=%02h busy=1",
               valid_a, valid_b, dout_a, busy, ea);
    end
    step();
    checks++;
    if (valid_b !== 1'b1 || valid_a !== 1'b0 || dout_b !== eb || dout_a !== ea || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_b: vb=%b va=%b b=%02h a=%02h busy=%b, expected vb=1 va=0 b=%02h a=%02h busy=0",
               valid_b, valid_a, dout_b, dout_a, busy, eb, ea);
    end
    pa = pa + ia;
    pb = pb + ib;
  endtask

  task automatic test_basic();
    test_reset();
    for (int i = 0; i < 3; i++) do_frame(8'h01, 8'h03, 8'h00);
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 4; i++) do_frame(8'h80, 8'h00, 8'h00);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL wrap_overrun: overrun=%b, expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    test_reset();
    incr_a = 1; incr_b = 3; tick = 1;
    step();
    tick = 0;
    step();
    tick = 1;
    step();
    tick = 0;
    checks++;
    if (overrun !== 1'b1 || valid_a !== 1'b1 || dout_a !== 8'h00) begin
      errors++;
      $display("FAIL overrun_set: ovr=%b va=%b a=%02h, expected ovr=1 va=1 a=00", overrun, valid_a, dout_a);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses += int'(valid_a) + int'(valid_b);
    end
    checks++;
    if (pulses !== 1 || overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_hold: pulses=%0d ovr=%b busy=%b, expected pulses=1 ovr=1 busy=0",
               pulses, overrun, busy);
    end
    pa = 8'h01; pb = 8'h03;
    do_frame(8'h01, 8'h03, 8'h00);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b, expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    test_reset();
    do_frame(8'h05, 8'h07, 8'h00);
    incr_a = 8'h09; tick = 1;
    step();
    tick = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({rom_addr, dout_a, dout_b, valid_a, valid_b, busy, overrun} !== 28'h0) begin
      errors++;
      $display("FAIL reset_mid: addr=%02h a=%02h b=%02h va=%b vb=%b busy=%b ovr=%b, expected all 0",
               rom_addr, dout_a, dout_b, valid_a, valid_b, busy, overrun);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += int'(valid_a) + int'(valid_b) + int'(busy);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity=%0d, expected 0", pulses);
    end
    pa = 0; pb = 0;
    do_frame(8'h01, 8'h01, 8'h00);
  endtask

  task automatic test_mid_incr();
    test_reset();
    do_frame(8'h01, 8'h02, 8'h00);
    do_frame(8'h10, 8'h20, 8'h00);
    do_frame(8'h00, 8'h00, 8'h00);
    checks++;
    if (pa !== 8'h11 || dout_a !== 8'h11) begin
      errors++;
      $display("FAIL mid_incr: a=%02h, expected 11", dout_a);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int f = 0; f < 40; f++) begin
      int gap;
      do_frame(8'($urandom), 8'($urandom), 8'($urandom));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap: va=%b vb=%b busy=%b, expected 0 0 0", valid_a, valid_b, busy);
        end
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL random_overrun: overrun=%b, expected 0", overrun);
    end
  endtask

`ifdef SINE_ROM_SEQ_OFFSET_EN
  task automatic test_offset();
    test_reset();
    for (int i = 0; i < 4; i++) do_frame(8'h40, 8'($urandom), 8'h40);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_reset_mid();
    test_mid_incr();
    test_random();
`ifdef SINE_ROM_SEQ_OFFSET_EN
    test_offset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
